// File: rtl/ctrl_pipe_pkg.sv
// Shared types and defaults for the decoded-control pipeline.
// Holds the E-stage control word layout and its M/W-stage subset.
package ctrl_pipe_pkg;

    localparam int unsigned CTRL_W      = 8;
    localparam int unsigned CTRL_STAGES = 3;

    typedef struct packed {
        logic       memtoreg;
        logic       memwrite;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic [2:0] alucontrol;
    } ctrl_e_t;

    typedef struct packed {
        logic memtoreg;
        logic memwrite;
        logic regwrite;
    } ctrl_mw_t;

    function automatic ctrl_mw_t ctrl_to_mw(input ctrl_e_t c);
        ctrl_mw_t m;
        m.memtoreg = c.memtoreg;
        m.memwrite = c.memwrite;
        m.regwrite = c.regwrite;
        return m;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register for a control word plus its valid bit.
// Priority at the edge: flush clears, hold keeps, bubble clears, else load.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = CTRL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (flush_i || (!hold_i && bubble_i)) begin
            data_d  = '0;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            data_d  = data_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe_chain.sv
// Parametrised control-word pipeline with per-stage stall/flush, stall
// back-propagation, bubble insertion and saturating retire/bubble counters.
module ctrl_pipe_chain
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = CTRL_W,
    parameter int unsigned STAGES = CTRL_STAGES,
    parameter int unsigned CNTW   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        d_in,
    input  logic                    valid_in,
    input  logic [STAGES-1:0]       stall,
    input  logic [STAGES-1:0]       flush,
    input  logic                    cnt_clr,
    output logic [STAGES*WIDTH-1:0] stage_data,
    output logic [STAGES-1:0]       stage_valid,
    output logic [STAGES-1:0]       hold,
    output logic [CNTW-1:0]         retire_cnt,
    output logic [CNTW-1:0]         bubble_cnt
);

    localparam int unsigned SUMW = CNTW + 1;
    localparam logic [SUMW-1:0] SAT = {1'b0, {CNTW{1'b1}}};

    logic [STAGES-1:0] e;
    logic [STAGES-1:0] bub;
    logic              retire_ev;
    logic [SUMW-1:0]   bub_n;
    logic [SUMW-1:0]   retire_sum, bubble_sum;
    logic [CNTW-1:0]   retire_q, retire_d;
    logic [CNTW-1:0]   bubble_q, bubble_d;

    // A stall holds its own stage and everything upstream of it.
    always_comb begin
        e = stall;
        for (int i = int'(STAGES) - 1; i > 0; i--) begin
            e[i-1] = stall[i-1] | e[i];
        end
    end

    // Bubble where a held stage feeds a moving, unflushed one.
    always_comb begin
        bub = '0;
        for (int i = 1; i < int'(STAGES); i++) begin
            bub[i] = e[i-1] & ~e[i] & ~flush[i];
        end
    end

    assign hold = e;

    for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;
        if (g == 0) begin : g_head
            assign src_data  = d_in;
            assign src_valid = valid_in;
        end else begin : g_body
            assign src_data  = stage_data[(g-1)*WIDTH +: WIDTH];
            assign src_valid = stage_valid[g-1];
        end
        ctrl_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clk      (clk),
            .rst      (reset),
            .flush_i  (flush[g]),
            .hold_i   (e[g]),
            .bubble_i (bub[g]),
            .data_i   (src_data),
            .valid_i  (src_valid),
            .data_o   (stage_data[g*WIDTH +: WIDTH]),
            .valid_o  (stage_valid[g])
        );
    end

    assign retire_ev = stage_valid[STAGES-1] & ~e[STAGES-1];

    // Saturating counters; clear beats increment.
    always_comb begin
        bub_n = '0;
        for (int i = 0; i < int'(STAGES); i++) begin
            bub_n = bub_n + SUMW'(bub[i]);
        end
        retire_sum = {1'b0, retire_q} + SUMW'(retire_ev);
        bubble_sum = {1'b0, bubble_q} + bub_n;
        retire_d   = (retire_sum > SAT) ? SAT[CNTW-1:0] : retire_sum[CNTW-1:0];
        bubble_d   = (bubble_sum > SAT) ? SAT[CNTW-1:0] : bubble_sum[CNTW-1:0];
        if (cnt_clr) begin
            retire_d = '0;
            bubble_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_q <= '0;
            bubble_q <= '0;
        end else begin
            retire_q <= retire_d;
            bubble_q <= bubble_d;
        end
    end

    assign retire_cnt = retire_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Directed bench for ctrl_pipe_chain (WIDTH=8, STAGES=3, CNTW=4): vector
// table for streaming/stall/flush, hand sequences for reset and saturation.
module tb_ctrl_pipe_chain;

    localparam int unsigned W  = 8;
    localparam int unsigned S  = 3;
    localparam int unsigned CW = 4;
    localparam int unsigned NV = 17;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   d_in = '0;
    logic           valid_in = 1'b0;
    logic [S-1:0]   stall = '0;
    logic [S-1:0]   flush = '0;
    logic           cnt_clr = 1'b0;
    logic [S*W-1:0] stage_data;
    logic [S-1:0]   stage_valid;
    logic [S-1:0]   hold;
    logic [CW-1:0]  retire_cnt;
    logic [CW-1:0]  bubble_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ctrl_pipe_chain #(.WIDTH(W), .STAGES(S), .CNTW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .d_in        (d_in),
        .valid_in    (valid_in),
        .stall       (stall),
        .flush       (flush),
        .cnt_clr     (cnt_clr),
        .stage_data  (stage_data),
        .stage_valid (stage_valid),
        .hold        (hold),
        .retire_cnt  (retire_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    typedef struct {
        logic [2:0]  stall;
        logic [2:0]  flush;
        logic        vin;
        logic [7:0]  din;
        logic        clr;
        logic [2:0]  hold;
        logic [23:0] data;
        logic [2:0]  valid;
        logic [3:0]  r;
        logic [3:0]  b;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [2:0] st, input logic [2:0] fl, input logic vi,
                       input logic [7:0] di, input logic cl);
        @(negedge clk);
        stall = st; flush = fl; valid_in = vi; d_in = di; cnt_clr = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string name, input logic [23:0] data, input logic [2:0] valid);
        chk({name, "_data"},  32'(stage_data),  32'(data));
        chk({name, "_valid"}, 32'(stage_valid), 32'(valid));
    endtask

    initial begin
        //            stall   flush   vin   din    clr   hold    data        valid   r  b
        tbl[0]  = '{3'b000, 3'b000, 1'b1, 8'hA5, 1'b0, 3'b000, 24'h0000A5, 3'b001, 0, 0};
        tbl[1]  = '{3'b000, 3'b000, 1'b1, 8'h3C, 1'b0, 3'b000, 24'h00A53C, 3'b011, 0, 0};
        tbl[2]  = '{3'b000, 3'b000, 1'b1, 8'h0F, 1'b0, 3'b000, 24'hA53C0F, 3'b111, 0, 0};
        tbl[3]  = '{3'b000, 3'b000, 1'b1, 8'h01, 1'b0, 3'b000, 24'h3C0F01, 3'b111, 1, 0};
        tbl[4]  = '{3'b000, 3'b000, 1'b1, 8'h02, 1'b0, 3'b000, 24'h0F0102, 3'b111, 2, 0};
        tbl[5]  = '{3'b010, 3'b000, 1'b1, 8'h03, 1'b0, 3'b011, 24'h000102, 3'b011, 3, 1};
        tbl[6]  = '{3'b010, 3'b000, 1'b1, 8'h03, 1'b0, 3'b011, 24'h000102, 3'b011, 3, 2};
        tbl[7]  = '{3'b000, 3'b000, 1'b1, 8'h03, 1'b0, 3'b000, 24'h010203, 3'b111, 3, 2};
        tbl[8]  = '{3'b100, 3'b000, 1'b1, 8'h04, 1'b0, 3'b111, 24'h010203, 3'b111, 3, 2};
        tbl[9]  = '{3'b000, 3'b000, 1'b1, 8'h04, 1'b0, 3'b000, 24'h020304, 3'b111, 4, 2};
        tbl[10] = '{3'b000, 3'b000, 1'b1, 8'h55, 1'b0, 3'b000, 24'h030455, 3'b111, 5, 2};
        tbl[11] = '{3'b010, 3'b010, 1'b1, 8'h66, 1'b0, 3'b011, 24'h000055, 3'b001, 6, 3};
        tbl[12] = '{3'b000, 3'b000, 1'b1, 8'h66, 1'b0, 3'b000, 24'h005566, 3'b011, 6, 3};
        tbl[13] = '{3'b000, 3'b000, 1'b1, 8'h77, 1'b0, 3'b000, 24'h556677, 3'b111, 6, 3};
        tbl[14] = '{3'b111, 3'b111, 1'b0, 8'h88, 1'b0, 3'b111, 24'h000000, 3'b000, 6, 3};
        tbl[15] = '{3'b000, 3'b000, 1'b0, 8'h88, 1'b0, 3'b000, 24'h000088, 3'b000, 6, 3};
        tbl[16] = '{3'b000, 3'b000, 1'b0, 8'h00, 1'b1, 3'b000, 24'h008800, 3'b000, 0, 0};

        #2 reset = 1'b1;
        #1;
        chk_state("reset", 24'h0, 3'b000);
        chk("reset_retire", 32'(retire_cnt), 32'd0);
        chk("reset_bubble", 32'(bubble_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < int'(NV); i++) begin
            @(negedge clk);
            stall = tbl[i].stall; flush = tbl[i].flush; valid_in = tbl[i].vin;
            d_in = tbl[i].din; cnt_clr = tbl[i].clr;
            #1;
            chk($sformatf("vec%0d_hold", i), 32'(hold), 32'(tbl[i].hold));
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", i), tbl[i].data, tbl[i].valid);
            chk($sformatf("vec%0d_retire", i), 32'(retire_cnt), 32'(tbl[i].r));
            chk($sformatf("vec%0d_bubble", i), 32'(bubble_cnt), 32'(tbl[i].b));
        end

        // Asynchronous reset between edges while the pipe is busy.
        cyc(3'b000, 3'b000, 1'b1, 8'h11, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 8'h22, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 8'h33, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 8'h44, 1'b0);
        chk_state("prerst", 24'h223344, 3'b111);
        chk("prerst_retire", 32'(retire_cnt), 32'd1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk_state("asyncrst", 24'h0, 3'b000);
        chk("asyncrst_retire", 32'(retire_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b0; valid_in = 1'b0; d_in = '0;
        cyc(3'b000, 3'b000, 1'b1, 8'h9A, 1'b0);
        cyc(3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        chk("lat_edge2_valid", 32'(stage_valid), 32'b010);
        cyc(3'b000, 3'b000, 1'b0, 8'h00, 1'b0);
        chk("lat_edge3_s2", 32'(stage_data[23:16]), 32'h9A);
        chk("lat_edge3_valid", 32'(stage_valid), 32'b100);

        // Retire counter saturation and clear-over-increment.
        cyc(3'b000, 3'b000, 1'b1, 8'hD0, 1'b1);
        for (int i = 0; i < 20; i++) cyc(3'b000, 3'b000, 1'b1, 8'(i), 1'b0);
        chk("retire_sat", 32'(retire_cnt), 32'd15);
        cyc(3'b000, 3'b000, 1'b1, 8'hE0, 1'b1);
        chk("retire_clr", 32'(retire_cnt), 32'd0);
        cyc(3'b000, 3'b000, 1'b1, 8'hE1, 1'b0);
        chk("retire_after_clr", 32'(retire_cnt), 32'd1);
        chk("bubble_before_sat", 32'(bubble_cnt), 32'd0);

        // Bubble counter saturation under a long mid-pipe stall.
        for (int i = 0; i < 20; i++) cyc(3'b010, 3'b000, 1'b1, 8'hE2, 1'b0);
        chk("bubble_hold", 32'(hold), 32'b011);
        chk("bubble_sat", 32'(bubble_cnt), 32'd15);

        // Flushed stage under a downstream stall stays cleared; refill is not a bubble.
        cyc(3'b000, 3'b000, 1'b1, 8'hC1, 1'b1);
        cyc(3'b000, 3'b000, 1'b1, 8'hC2, 1'b0);
        cyc(3'b000, 3'b000, 1'b1, 8'hC3, 1'b0);
        chk_state("refill", 24'hC1C2C3, 3'b111);
        cyc(3'b100, 3'b010, 1'b1, 8'hC4, 1'b0);
        chk_state("hflush", 24'hC100C3, 3'b101);
        cyc(3'b100, 3'b000, 1'b1, 8'hC4, 1'b0);
        chk_state("hflush_hold1", 24'hC100C3, 3'b101);
        cyc(3'b100, 3'b000, 1'b1, 8'hC4, 1'b0);
        chk_state("hflush_hold2", 24'hC100C3, 3'b101);
        cyc(3'b000, 3'b000, 1'b1, 8'hC4, 1'b0);
        chk_state("hflush_release", 24'h00C3C4, 3'b011);
        chk("hflush_bubble", 32'(bubble_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_chain.md
Name: ctrl_pipe_chain

Overview:
Parametrised control-signal pipeline replacing the fixed per-stage flop/clear-flop chains that carry decoded control bits from Decode through the back-end stages. Carries a WIDTH-bit control word plus a valid bit through STAGES registers, each with its own stall and flush. Stalls propagate downstream-to-upstream automatically, and bubbles are inserted where a held stage feeds a moving one. Saturating retire and bubble counters support performance debug.

Parameters:
WIDTH, 8, bits of control word per stage
STAGES, 3, number of pipeline registers (>=1; stage 0 is fed by d_in)
CNTW, 16, width of each performance counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
d_in  input  WIDTH  control word from decoder
valid_in  input  1  d_in is a real instruction
stall  input  STAGES  stall[i] requests stage i hold
flush  input  STAGES  flush[i] clears stage i
cnt_clr  input  1  synchronous clear of both counters
stage_data  output  STAGES*WIDTH  register contents; stage i at bits [i*WIDTH +: WIDTH]
stage_valid  output  STAGES  valid bit per stage
hold  output  STAGES  effective stall per stage (hold[i] = e[i])
retire_cnt  output  CNTW  instructions leaving the last stage
bubble_cnt  output  CNTW  bubbles inserted by stall boundaries

Behaviour:
- Reset (async, active-high): every stage_data = 0, stage_valid = 0, both counters = 0. Applies immediately, including mid-stall or mid-flush. Outputs are registers.
- Effective stall is combinational: e[STAGES-1] = stall[STAGES-1]; e[i] = stall[i] | e[i+1]. A held stage therefore always holds everything upstream of it.
- Per-stage next state at each rising edge, evaluated in priority order:
  1. flush[i]: data = 0, valid = 0. Flush wins over stall.
  2. e[i]: hold data and valid.
  3. i>0 and e[i-1]: insert bubble; data = 0, valid = 0.
  4. Otherwise load from source. For i=0 the source is d_in/valid_in; for i>0 it is stage i-1 (pre-edge value).
- A flushed stage i with i>0 that is held by a downstream stall stays cleared (valid 0) for the rest of the hold.
- Latency: d_in appears at stage k after k+1 edges when there are no stalls.
- When stage i is loaded from a flushed or bubbled stage i-1, it receives zeros. This is normal propagation and is not counted as a bubble.
- retire event: stage_valid[STAGES-1] = 1 and e[STAGES-1] = 0 at the edge.
- bubble event: the number of stages taking rule 3 at the edge. Add it to bubble_cnt; with monotonic e this is at most 1 per cycle.
- Counters saturate at 2^CNTW-1 and never wrap.
- cnt_clr: both counters load 0. It takes priority over an increment in the same cycle.
- STAGES=1: rule 3 never applies and bubble_cnt stays 0.
- flush and stall asserted together on all stages: everything clears; counters increment only per the rules above.

Decomposition:
- Shared package ctrl_pipe_pkg: localparam defaults (CTRL_W=8, CTRL_STAGES=3) and a typedef for the E-stage control word. Field order is {memtoreg, memwrite, alusrc, regdst, regwrite, alucontrol[2:0]}. A matching M/W-stage subset typedef also goes in the package.
- Sub-module ctrl_stage_reg: one WIDTH+1-bit register with async reset and sync clear/enable/bubble select. It is instantiated STAGES times in a generate loop. The e-chain and counters stay in the top.

Test Plan:
- STAGES=3, WIDTH=8, no stalls: d_in = 8'hA5, 8'h3C, 8'h0F on consecutive cycles with valid_in=1 -> stage2 shows A5, 3C, 0F on edges 3, 4, 5; retire_cnt = 3 after edge 6.
- stall = 3'b010 for 2 cycles while streaming 01, 02, 03, ... -> stages 0 and 1 hold, hold = 3'b011, stage2 receives two bubbles (valid 0), bubble_cnt += 2, and no word is lost or duplicated afterwards.
- stall = 3'b100 alone -> hold = 3'b111, entire pipe frozen, retire_cnt and bubble_cnt unchanged.
- flush[1] together with stall[1] for 1 cycle holding 8'h55 -> stage1 becomes 00/valid 0 (flush wins). The next stage2 value is 00/valid 0 and is not counted as a bubble.
- Assert reset asynchronously mid-stream between edges -> all outputs 0 immediately. After release, the first valid_in word reaches stage2 after 3 edges.
- CNTW=4: retire 20 instructions -> retire_cnt sticks at 15. cnt_clr together with a retire -> retire_cnt = 0.
